// File: rtl/pointer_scan_ctrl_if.sv
// Handshake bundle between the row/column scan controller and its datapath.
// The master drives the scan request and element acknowledge; the slave is the controller.
interface pointer_scan_ctrl_if;
    logic       start;
    logic [7:0] rows;
    logic [7:0] cols;
    logic       elem_ack;
    logic       abort;
    logic       elem_req;
    logic       cp_inc;
    logic       cp_rst;
    logic       rp_inc;
    logic       rp_rst;
    logic [7:0] row_idx;
    logic [7:0] col_idx;
    logic       busy;
    logic       done;

    modport master (
        output start, rows, cols, elem_ack, abort,
        input  elem_req, cp_inc, cp_rst, rp_inc, rp_rst, row_idx, col_idx, busy, done
    );

    modport slave (
        input  start, rows, cols, elem_ack, abort,
        output elem_req, cp_inc, cp_rst, rp_inc, rp_rst, row_idx, col_idx, busy, done
    );
endinterface

// File: rtl/pointer_scan_ctrl.sv
// Row-major element scan sequencer driving external row/column pointer registers.
// All outputs are registered together with the state, so they line up with the state they describe.
//
//   state | meaning
//   IDLE  | waiting for start; indices hold the last scan's values
//   LOAD  | restore both pointers to base (cp_rst/rp_rst)
//   RUN   | elem_req high until the datapath acknowledges
//   STEP  | one-cycle gap carrying the pointer increment/restore strobes
//   FIN   | one-cycle done pulse
module pointer_scan_ctrl (
    input  logic                Clk,
    input  logic                RSTn,
    pointer_scan_ctrl_if.slave  scan
);

    typedef enum logic [2:0] {IDLE, LOAD, RUN, STEP, FIN} state_t;

    state_t     state;
    logic [7:0] rows_q;
    logic [7:0] cols_q;
    logic [7:0] row_idx;
    logic [7:0] col_idx;
    logic       elem_req;
    logic       cp_inc;
    logic       cp_rst;
    logic       rp_inc;
    logic       rp_rst;
    logic       busy;
    logic       done;
    logic       last_col;
    logic       last_row;

    // Only evaluated in RUN, where both latched bounds are known to be non-zero.
    assign last_col = (col_idx == cols_q - 8'd1);
    assign last_row = (row_idx == rows_q - 8'd1);

    always_ff @(posedge Clk) begin
        if (!RSTn) begin
            state    <= IDLE;
            rows_q   <= 8'd0;
            cols_q   <= 8'd0;
            row_idx  <= 8'd0;
            col_idx  <= 8'd0;
            elem_req <= 1'b0;
            cp_inc   <= 1'b0;
            cp_rst   <= 1'b0;
            rp_inc   <= 1'b0;
            rp_rst   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            cp_inc <= 1'b0;
            cp_rst <= 1'b0;
            rp_inc <= 1'b0;
            rp_rst <= 1'b0;
            done   <= 1'b0;
            if (scan.abort && (state inside {LOAD, RUN, STEP})) begin
                // Abort leaves the pointer registers parked at base.
                state    <= IDLE;
                busy     <= 1'b0;
                elem_req <= 1'b0;
                cp_rst   <= 1'b1;
                rp_rst   <= 1'b1;
                row_idx  <= 8'd0;
                col_idx  <= 8'd0;
            end else begin
                case (state)
                    IDLE: begin
                        if (scan.start) begin
                            rows_q  <= scan.rows;
                            cols_q  <= scan.cols;
                            row_idx <= 8'd0;
                            col_idx <= 8'd0;
                            cp_rst  <= 1'b1;
                            rp_rst  <= 1'b1;
                            busy    <= 1'b1;
                            state   <= LOAD;
                        end
                    end
                    LOAD: begin
                        if (rows_q == 8'd0 || cols_q == 8'd0) begin
                            done  <= 1'b1;
                            state <= FIN;
                        end else begin
                            elem_req <= 1'b1;
                            state    <= RUN;
                        end
                    end
                    RUN: begin
                        if (scan.elem_ack) begin
                            elem_req <= 1'b0;
                            if (!last_col) begin
                                cp_inc  <= 1'b1;
                                col_idx <= col_idx + 8'd1;
                                state   <= STEP;
                            end else if (!last_row) begin
                                cp_rst  <= 1'b1;
                                rp_inc  <= 1'b1;
                                col_idx <= 8'd0;
                                row_idx <= row_idx + 8'd1;
                                state   <= STEP;
                            end else begin
                                done  <= 1'b1;
                                state <= FIN;
                            end
                        end
                    end
                    STEP: begin
                        elem_req <= 1'b1;
                        state    <= RUN;
                    end
                    FIN: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: begin
                        busy     <= 1'b0;
                        elem_req <= 1'b0;
                        state    <= IDLE;
                    end
                endcase
            end
        end
    end

    assign scan.elem_req = elem_req;
    assign scan.cp_inc   = cp_inc;
    assign scan.cp_rst   = cp_rst;
    assign scan.rp_inc   = rp_inc;
    assign scan.rp_rst   = rp_rst;
    assign scan.row_idx  = row_idx;
    assign scan.col_idx  = col_idx;
    assign scan.busy     = busy;
    assign scan.done     = done;

endmodule

// File: tb/tb_pointer_scan_ctrl.sv
// Bench for pointer_scan_ctrl: fixed scan table, hand-written abort/reset sequences,
// and randomized scans compared against an arithmetic scan model.
module tb_pointer_scan_ctrl;

    logic Clk = 1'b0;
    logic RSTn;
    always #5 Clk = ~Clk;

    pointer_scan_ctrl_if scan();

    pointer_scan_ctrl dut (
        .Clk  (Clk),
        .RSTn (RSTn),
        .scan (scan.slave)
    );

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int rows;
        int cols;
        int delay;
        bit noise;
        int cp_inc;
        int cp_rst;
        int rp_inc;
        int rp_rst;
        int elems;
        int latency;
        int frow;
        int fcol;
    } vec_t;

    typedef struct {
        int cp_inc;
        int cp_rst;
        int rp_inc;
        int rp_rst;
        int elems;
        int latency;
        int busy_n;
        int done_n;
        int frow;
        int fcol;
        int idx_errs;
        int conflicts;
        int sumd;
        int timeout;
        int post_busy;
        int post_done;
        int post_row;
        int post_col;
    } res_t;

    vec_t tbl[7];

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Scan model: row-major visit of rows*cols elements, each element costs its wait
    // cycles plus one RUN cycle, one STEP between elements, plus LOAD and FIN.
    function automatic vec_t model(input int r, input int c, input int sumd);
        vec_t e;
        int n;
        n = r * c;
        e.rows = r;
        e.cols = c;
        e.delay = 0;
        e.noise = 1'b0;
        e.rp_rst = 1;
        if (n == 0) begin
            e.cp_inc = 0;
            e.cp_rst = 1;
            e.rp_inc = 0;
            e.elems = 0;
            e.latency = 2;
            e.frow = 0;
            e.fcol = 0;
        end else begin
            e.cp_inc = r * (c - 1);
            e.cp_rst = r;
            e.rp_inc = r - 1;
            e.elems = n;
            e.latency = 1 + (n + sumd) + (n - 1) + 1;
            e.frow = r - 1;
            e.fcol = c - 1;
        end
        return e;
    endfunction

    // dly >= 0: every element acknowledged after dly waiting cycles (0 => ack held high).
    // dly < 0: random wait per element.
    task automatic run_scan(input int r, input int c, input int dly, input bit noise, output res_t res);
        int cnt;
        int d;
        int er;
        int ec;
        bit seen_done;
        res = '{default: 0};
        er = 0;
        ec = 0;
        cnt = 0;
        d = (dly < 0) ? int'($urandom_range(0, 3)) : dly;
        scan.rows = r[7:0];
        scan.cols = c[7:0];
        scan.start = 1'b1;
        scan.elem_ack = (dly == 0);
        tick();
        scan.start = 1'b0;
        seen_done = 1'b0;
        for (int cyc = 1; cyc <= 3000 && !seen_done; cyc++) begin
            if (scan.busy) res.busy_n++;
            if (scan.cp_inc) res.cp_inc++;
            if (scan.cp_rst) res.cp_rst++;
            if (scan.rp_inc) res.rp_inc++;
            if (scan.rp_rst) res.rp_rst++;
            if ((scan.cp_inc && scan.cp_rst) || (scan.rp_inc && scan.rp_rst)) res.conflicts++;
            if (scan.done) begin
                seen_done = 1'b1;
                res.done_n++;
                res.latency = cyc;
                res.frow = int'(scan.row_idx);
                res.fcol = int'(scan.col_idx);
            end
            if (scan.elem_req) begin
                if (cnt == 0) begin
                    res.elems++;
                    if (int'(scan.row_idx) != er || int'(scan.col_idx) != ec) res.idx_errs++;
                end
                if (dly != 0) scan.elem_ack = (cnt == d);
                if (cnt == d) begin
                    res.sumd += d;
                    cnt = 0;
                    d = (dly < 0) ? int'($urandom_range(0, 3)) : dly;
                    if (ec == c - 1) begin
                        ec = 0;
                        er++;
                    end else begin
                        ec++;
                    end
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
                if (dly != 0) scan.elem_ack = ($urandom_range(0, 1) == 1);
            end
            if (noise && scan.busy && !scan.done) begin
                scan.start = ($urandom_range(0, 3) == 0);
                scan.rows = 8'($urandom);
                scan.cols = 8'($urandom);
            end else begin
                scan.start = 1'b0;
            end
            if (!seen_done) tick();
        end
        if (!seen_done) res.timeout = 1;
        scan.start = 1'b0;
        scan.elem_ack = 1'b0;
        tick();
        res.post_busy = int'(scan.busy);
        res.post_done = int'(scan.done);
        res.post_row = int'(scan.row_idx);
        res.post_col = int'(scan.col_idx);
    endtask

    task automatic compare(input string tag, input res_t res, input vec_t e);
        check({tag, ".timeout"}, res.timeout, 0);
        check({tag, ".cp_inc"}, res.cp_inc, e.cp_inc);
        check({tag, ".cp_rst"}, res.cp_rst, e.cp_rst);
        check({tag, ".rp_inc"}, res.rp_inc, e.rp_inc);
        check({tag, ".rp_rst"}, res.rp_rst, e.rp_rst);
        check({tag, ".elems"}, res.elems, e.elems);
        check({tag, ".latency"}, res.latency, e.latency);
        check({tag, ".busy_cycles"}, res.busy_n, e.latency);
        check({tag, ".done_pulses"}, res.done_n, 1);
        check({tag, ".final_row"}, res.frow, e.frow);
        check({tag, ".final_col"}, res.fcol, e.fcol);
        check({tag, ".index_order_errs"}, res.idx_errs, 0);
        check({tag, ".strobe_conflicts"}, res.conflicts, 0);
        check({tag, ".busy_after"}, res.post_busy, 0);
        check({tag, ".done_after"}, res.post_done, 0);
        check({tag, ".hold_row"}, res.post_row, e.frow);
        check({tag, ".hold_col"}, res.post_col, e.fcol);
    endtask

    task automatic check_outputs(input string tag, input int exp_busy, input int exp_cprst,
                                 input int exp_rprst);
        check({tag, ".busy"}, int'(scan.busy), exp_busy);
        check({tag, ".done"}, int'(scan.done), 0);
        check({tag, ".elem_req"}, int'(scan.elem_req), 0);
        check({tag, ".cp_inc"}, int'(scan.cp_inc), 0);
        check({tag, ".rp_inc"}, int'(scan.rp_inc), 0);
        check({tag, ".cp_rst"}, int'(scan.cp_rst), exp_cprst);
        check({tag, ".rp_rst"}, int'(scan.rp_rst), exp_rprst);
        check({tag, ".row_idx"}, int'(scan.row_idx), 0);
        check({tag, ".col_idx"}, int'(scan.col_idx), 0);
    endtask

    initial begin
        res_t res;
        vec_t e;
        bit found;
        int r;
        int c;

        tbl[0] = '{2, 3, 0, 1'b0, 4, 2, 1, 1, 6, 13, 1, 2};
        tbl[1] = '{0, 5, 0, 1'b0, 0, 1, 0, 1, 0, 2, 0, 0};
        tbl[2] = '{1, 4, 3, 1'b0, 3, 1, 0, 1, 4, 21, 0, 3};
        tbl[3] = '{3, 3, 1, 1'b1, 6, 3, 2, 1, 9, 28, 2, 2};
        tbl[4] = '{1, 1, 0, 1'b0, 0, 1, 0, 1, 1, 3, 0, 0};
        tbl[5] = '{4, 0, 2, 1'b0, 0, 1, 0, 1, 0, 2, 0, 0};
        tbl[6] = '{5, 2, 2, 1'b1, 5, 5, 4, 1, 10, 41, 4, 1};

        RSTn = 1'b0;
        scan.start = 1'b0;
        scan.rows = 8'd0;
        scan.cols = 8'd0;
        scan.elem_ack = 1'b0;
        scan.abort = 1'b0;
        tick();
        tick();
        check_outputs("reset", 0, 0, 0);
        RSTn = 1'b1;
        tick();
        check_outputs("reset_release", 0, 0, 0);

        for (int i = 0; i < 7; i++) begin
            run_scan(tbl[i].rows, tbl[i].cols, tbl[i].delay, tbl[i].noise, res);
            compare($sformatf("table%0d", i), res, tbl[i]);
        end

        // Abort while RUN sits on element (1,1) of a 3x3 scan; ack held high to show abort wins.
        scan.rows = 8'd3;
        scan.cols = 8'd3;
        scan.elem_ack = 1'b1;
        scan.start = 1'b1;
        tick();
        scan.start = 1'b0;
        found = 1'b0;
        for (int cyc = 0; cyc < 100 && !found; cyc++) begin
            if (scan.elem_req && scan.row_idx == 8'd1 && scan.col_idx == 8'd1) found = 1'b1;
            else tick();
        end
        check("abort_reach_1_1", int'(found), 1);
        scan.abort = 1'b1;
        tick();
        check_outputs("abort_run", 0, 1, 1);
        scan.abort = 1'b0;
        scan.elem_ack = 1'b0;
        tick();
        check_outputs("abort_run_next", 0, 0, 0);

        // Abort in IDLE does nothing.
        scan.abort = 1'b1;
        tick();
        check_outputs("abort_idle", 0, 0, 0);
        scan.abort = 1'b0;

        // Abort during LOAD.
        scan.rows = 8'd2;
        scan.cols = 8'd2;
        scan.start = 1'b1;
        tick();
        scan.start = 1'b0;
        check("load_cp_rst", int'(scan.cp_rst), 1);
        scan.abort = 1'b1;
        tick();
        check_outputs("abort_load", 0, 1, 1);
        scan.abort = 1'b0;
        tick();

        // Abort while in FIN: done already pulsing, no restore strobes afterwards.
        scan.rows = 8'd1;
        scan.cols = 8'd1;
        scan.elem_ack = 1'b1;
        scan.start = 1'b1;
        tick();
        scan.start = 1'b0;
        tick();
        check("fin_seq_elem_req", int'(scan.elem_req), 1);
        tick();
        check("fin_seq_done", int'(scan.done), 1);
        scan.abort = 1'b1;
        tick();
        scan.abort = 1'b0;
        scan.elem_ack = 1'b0;
        check("abort_fin_cp_rst", int'(scan.cp_rst), 0);
        check("abort_fin_busy", int'(scan.busy), 0);
        check("abort_fin_hold_row", int'(scan.row_idx), 0);

        // Reset while in STEP.
        scan.rows = 8'd2;
        scan.cols = 8'd3;
        scan.elem_ack = 1'b1;
        scan.start = 1'b1;
        tick();
        scan.start = 1'b0;
        found = 1'b0;
        for (int cyc = 0; cyc < 100 && !found; cyc++) begin
            if (scan.busy && !scan.elem_req && scan.cp_inc) found = 1'b1;
            else tick();
        end
        check("reset_reach_step", int'(found), 1);
        RSTn = 1'b0;
        tick();
        check_outputs("reset_step", 0, 0, 0);
        RSTn = 1'b1;
        scan.elem_ack = 1'b0;
        tick();
        check_outputs("reset_step_next", 0, 0, 0);

        // Randomized scans with random ack waits and stray start pulses mid-scan.
        for (int i = 0; i < 20; i++) begin
            r = int'($urandom_range(0, 4));
            c = int'($urandom_range(0, 5));
            run_scan(r, c, -1, 1'b1, res);
            e = model(r, c, res.sumd);
            compare($sformatf("rand%0d_%0dx%0d", i, r, c), res, e);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pointer_scan_ctrl.md
POINTER_SCAN_CTRL -- requirements
Module: pointer_scan_ctrl

Interface
REQ-001 Clk  input  1  single clock; all state updates on rising edge.
REQ-002 RSTn  input  1  reset is synchronous and active-low; sampled on rising Clk.
REQ-003 start  input  1  begin scan; sampled only in IDLE.
REQ-004 rows  input  8  row count; latched on accepted start.
REQ-005 cols  input  8  column count; latched on accepted start.
REQ-006 elem_ack  input  1  datapath finished current element.
REQ-007 abort  input  1  terminate scan.
REQ-008 elem_req  output  1  request datapath to process element at current pointers.
REQ-009 cp_inc / cp_rst  output  1 each  one-cycle strobes to column-pointer register (INC / restore-base).
REQ-010 rp_inc / rp_rst  output  1 each  one-cycle strobes to row-pointer register.
REQ-011 row_idx / col_idx  output  8 each  current element indices.
REQ-012 busy  output  1  high in any state except IDLE.
REQ-013 done  output  1  one-cycle pulse on normal scan completion.

Function
REQ-014 States SHALL be IDLE, LOAD, RUN, STEP, FIN; encoding free.
REQ-015 IDLE: start=1 -> latch rows/cols, row_idx=col_idx=0; next LOAD; start=0 -> stay.
REQ-016 LOAD: cp_rst=rp_rst=1 for exactly this cycle; next FIN if latched rows==0 or cols==0, else RUN.
REQ-017 RUN: elem_req=1 held; elem_ack=0 -> stay; elem_ack=1 -> evaluate advance (REQ-018..020).
REQ-018 Advance, col_idx<cols-1: next STEP with cp_inc=1 in STEP; col_idx+1.
REQ-019 Advance, col_idx==cols-1 and row_idx<rows-1: next STEP with cp_rst=1 and rp_inc=1 in STEP; col_idx=0, row_idx+1.
REQ-020 Advance, last element (col_idx==cols-1, row_idx==rows-1): next FIN; no inc/rst strobes.
REQ-021 STEP: elem_req=0 exactly one cycle; next RUN.
REQ-022 Consequence: elem_ack held high continuously -> one element per 2 cycles.
REQ-023 FIN: done=1 exactly one cycle; next IDLE; row_idx/col_idx hold final values until next start.
REQ-024 elem_ack outside RUN SHALL be ignored.
REQ-025 start outside IDLE SHALL be ignored; latched rows/cols not modified mid-scan.
REQ-026 abort=1 in LOAD/RUN/STEP: next IDLE; cp_rst=rp_rst=1 in that cycle's registered outputs; done stays 0; indices cleared to 0.
REQ-027 abort in IDLE or FIN: no effect (FIN still pulses done).
REQ-028 Priority: RSTn low > abort > elem_ack/start.
REQ-029 All strobes, elem_req, done, busy registered (driven from state regs, no combinational path from inputs).
REQ-030 Index arithmetic 8-bit unsigned; max scan 255x255; no wrap because bounds checked before increment.
REQ-031 At most one of cp_inc, cp_rst asserted per cycle; same for rp_inc, rp_rst.

Reset
REQ-032 RSTn=0 at rising Clk: state IDLE; elem_req, cp_inc, cp_rst, rp_inc, rp_rst, busy, done = 0; row_idx, col_idx, latched rows/cols = 0.
REQ-033 Reset mid-scan SHALL abandon scan with no done pulse and no strobes in the following cycle.

Verification
REQ-034 rows=2, cols=3, start, elem_ack=1 constant -> 6 elem_req high periods; cp_inc=4, cp_rst=2 (LOAD + row wrap), rp_rst=1, rp_inc=1; done once, 13 cycles after start sampled; final row_idx=1, col_idx=2.
REQ-035 rows=0, cols=5, start -> LOAD strobes cp_rst/rp_rst, done pulse next cycle, elem_req never high, busy high 2 cycles.
REQ-036 rows=1, cols=4, ack delayed 3 cycles per element -> elem_req held until ack, cp_inc=3, rp_inc=0, done once.
REQ-037 abort during RUN at element (1,1) of 3x3 -> next cycle IDLE, cp_rst=rp_rst=1, done=0, indices 0.
REQ-038 RSTn=0 during STEP -> next cycle all outputs 0; start pulse while busy in another run -> ignored, rows/cols unchanged.
